// File: rtl/rf_dbg_arbiter.sv
// Register-file port arbiter between writeback and a debug requester: stall, drain, single access, ack.
// Optional drain timeout with error ack is compiled in with RF_DBG_ARB_TIMEOUT_EN.
module rf_dbg_arbiter #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned AR_BITS       = 5,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we_i,
  input  logic [AR_BITS-1:0] wb_dst_i,
  input  logic [XLEN-1:0]    wb_r_i,
  input  logic               pipe_idle_i,
  input  logic               dbg_req_i,
  input  logic               dbg_we_i,
  input  logic [AR_BITS-1:0] dbg_addr_i,
  input  logic [XLEN-1:0]    dbg_wdata_i,
  output logic               dbg_ack_o,
  output logic [XLEN-1:0]    dbg_rdata_o,
  output logic               dbg_err_o,
  output logic               pipe_stall_o,
  output logic               rf_we_o,
  output logic [AR_BITS-1:0] rf_dst_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  output logic [AR_BITS-1:0] rf_dbg_src_o,
  input  logic [XLEN-1:0]    rf_dbg_q_i
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ACCESS,
    RDWAIT,
    ACK
`ifdef RF_DBG_ARB_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  state_t               state, next_state;
  logic                 req_we;
  logic [AR_BITS-1:0]   req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 drain_ok;
  logic                 dbg_wr;

  assign drain_ok = pipe_idle_i && !wb_we_i;
  // Writeback always wins the port; reset also suppresses a debug write still in ACCESS.
  assign dbg_wr   = (state == ACCESS) && req_we && (req_addr != '0) && !wb_we_i && !rst;

`ifdef RF_DBG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT);
  logic [CNT_W-1:0] drain_cnt;
  logic             drain_expired;

  assign drain_expired = (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));

  // Cleared while idle, so it is zero on every entry to DRAIN.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) drain_cnt <= '0;
    else if (state == DRAIN)  drain_cnt <= drain_cnt + 1'b1;
  end
`else
  logic unused_drain_timeout;
  assign unused_drain_timeout = (DRAIN_TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      dbg_rdata_o <= '0;
    end else begin
      if (state == IDLE && dbg_req_i) begin
        req_we    <= dbg_we_i;
        req_addr  <= dbg_addr_i;
        req_wdata <= dbg_wdata_i;
      end
      if (state == RDWAIT)
        dbg_rdata_o <= (req_addr == '0) ? '0 : rf_dbg_q_i;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (dbg_req_i) next_state = DRAIN;
      DRAIN: begin
        if (drain_ok) next_state = ACCESS;
`ifdef RF_DBG_ARB_TIMEOUT_EN
        else if (drain_expired) next_state = ERR;
`endif
      end
      ACCESS: if (!wb_we_i) next_state = req_we ? ACK : RDWAIT;
      RDWAIT: next_state = ACK;
      ACK:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pipe_stall_o = (state != IDLE);
`ifdef RF_DBG_ARB_TIMEOUT_EN
    dbg_ack_o    = (state == ACK) || (state == ERR);
    dbg_err_o    = (state == ERR);
`else
    dbg_ack_o    = (state == ACK);
    dbg_err_o    = 1'b0;
`endif
    rf_dbg_src_o = (state == ACCESS || state == RDWAIT) ? req_addr : '0;
    if (dbg_wr) begin
      rf_we_o    = 1'b1;
      rf_dst_o   = req_addr;
      rf_wdata_o = req_wdata;
    end else begin
      rf_we_o    = wb_we_i && (wb_dst_i != '0);
      rf_dst_o   = wb_dst_i;
      rf_wdata_o = wb_r_i;
    end
  end

endmodule

// File: tb/tb_rf_dbg_arbiter.sv
// Scoreboard bench for rf_dbg_arbiter: stimulus queues expected acks and register writes, monitors compare.
module tb_rf_dbg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_r;
  logic        pipe_idle;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack, dbg_err, pipe_stall, rf_we;
  logic [31:0] dbg_rdata, rf_wdata, rf_q;
  logic [4:0]  rf_dst, rf_src;

  rf_dbg_arbiter #(.XLEN(32), .AR_BITS(5), .DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_we_i(wb_we), .wb_dst_i(wb_dst), .wb_r_i(wb_r),
    .pipe_idle_i(pipe_idle),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .pipe_stall_o(pipe_stall),
    .rf_we_o(rf_we), .rf_dst_o(rf_dst), .rf_wdata_o(rf_wdata),
    .rf_dbg_src_o(rf_src), .rf_dbg_q_i(rf_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in; x0 holds junk so the arbiter must zero x0 reads itself.
  logic [31:0] rf_mem [32] = '{0: 32'hBAD0BAD0, default: '0};
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_dst] <= rf_wdata;
    rf_q <= rf_mem[rf_src];
  end

  typedef struct {int cyc; logic [31:0] rdata; logic err;} ack_t;
  typedef struct {int cyc; logic [4:0] dst; logic [31:0] data;} wr_t;
  ack_t ack_q[$];
  wr_t  wr_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  ack_t ea;
  always @(negedge clk) begin
    if (dbg_ack) begin
      if (ack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        ea = ack_q.pop_front();
        chk("ack_cycle", cyc, ea.cyc);
        chk("ack_rdata", dbg_rdata, ea.rdata);
        chk("ack_err", 32'(dbg_err), 32'(ea.err));
      end
    end else if (dbg_err) begin
      checks++; errors++;
      $display("FAIL err_without_ack: got err=1 expected 0 at cycle %0d", cyc);
    end
  end

  wr_t ew;
  always @(negedge clk) begin
    if (rf_we) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got x%0d=%h at cycle %0d expected none", rf_dst, rf_wdata, cyc);
      end else begin
        ew = wr_q.pop_front();
        chk("wr_cycle", cyc, ew.cyc);
        chk("wr_dst", 32'(rf_dst), 32'(ew.dst));
        chk("wr_data", rf_wdata, ew.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns with cyc == e0, the edge that captured the request; request inputs are then scrambled.
  task automatic start_req(input logic we, input logic [4:0] addr, input logic [31:0] wd, output int e0);
    step();
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    e0 = cyc + 1;
    step();
    dbg_we = ~we; dbg_addr = addr ^ 5'h1f; dbg_wdata = ~wd;
  endtask

  task automatic finish_req();
    int n = 0;
    while (!dbg_ack && n < 100) begin
      chk("stall_busy", 32'(pipe_stall), 32'd1);
      step();
      n++;
    end
    if (!dbg_ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
    end
    step();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    chk("stall_after_ack", 32'(pipe_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  int e0;
  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_dst = '0; wb_r = '0; pipe_idle = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset values and writeback pass-through while in reset; a write to x0 is dropped.
    step();
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_err", 32'(dbg_err), 32'd0);
    chk("rst_src", 32'(rf_src), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    wb_we = 1'b1; wb_dst = 5'd7; wb_r = 32'h77;
    wr_q.push_back('{cyc, 5'd7, 32'h77});
    step();
    wb_dst = 5'd0; wb_r = 32'h99;
    step();
    wb_we = 1'b0; rst = 1'b0;
    step();

    // Idle pipe write x5, then read it back.
    start_req(1'b1, 5'd5, 32'hDEADBEEF, e0);
    wr_q.push_back('{e0 + 1, 5'd5, 32'hDEADBEEF});
    ack_q.push_back('{e0 + 2, 32'h0, 1'b0});
    finish_req();

    start_req(1'b0, 5'd5, 32'h0, e0);
    ack_q.push_back('{e0 + 3, 32'hDEADBEEF, 1'b0});
    chk("src_in_drain", 32'(rf_src), 32'd0);
    step();
    chk("src_in_access", 32'(rf_src), 32'd5);
    finish_req();

    // x0: write is suppressed, read returns zero.
    start_req(1'b1, 5'd0, 32'h1234, e0);
    ack_q.push_back('{e0 + 2, 32'hDEADBEEF, 1'b0});
    finish_req();

    start_req(1'b0, 5'd0, 32'h0, e0);
    ack_q.push_back('{e0 + 3, 32'h0, 1'b0});
    finish_req();

    // Busy pipe for 7 drain cycles with writeback traffic to x3.
    pipe_idle = 1'b0;
    start_req(1'b1, 5'd9, 32'hCAFE0009, e0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      wb_we = 1'b1; wb_dst = 5'd3; wb_r = 32'h55;
      wr_q.push_back('{cyc, 5'd3, 32'h55});
      chk("stall_drain", 32'(pipe_stall), 32'd1);
    end
    step();
    wb_we = 1'b0; pipe_idle = 1'b1;
    wr_q.push_back('{e0 + 8, 5'd9, 32'hCAFE0009});
    ack_q.push_back('{e0 + 9, 32'h0, 1'b0});
    finish_req();

    // Writeback collides with ACCESS for 2 cycles; debug write lands after.
    start_req(1'b1, 5'd12, 32'h0BADF00D, e0);
    step();
    wb_we = 1'b1; wb_dst = 5'd12; wb_r = 32'h11111111;
    wr_q.push_back('{cyc, 5'd12, 32'h11111111});
    step();
    wb_r = 32'h22222222;
    wr_q.push_back('{cyc, 5'd12, 32'h22222222});
    step();
    wb_we = 1'b0;
    wr_q.push_back('{cyc, 5'd12, 32'h0BADF00D});
    ack_q.push_back('{e0 + 4, 32'h0, 1'b0});
    finish_req();

    start_req(1'b0, 5'd12, 32'h0, e0);
    ack_q.push_back('{e0 + 3, 32'h0BADF00D, 1'b0});
    finish_req();

    // Reset during RDWAIT: back to idle, no ack, read data cleared.
    start_req(1'b0, 5'd9, 32'h0, e0);
    step();
    step();
    rst = 1'b1; wb_we = 1'b1; wb_dst = 5'd4; wb_r = 32'h44;
    wr_q.push_back('{cyc, 5'd4, 32'h44});
    step();
    rst = 1'b0; wb_we = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    chk("rst_mid_stall", 32'(pipe_stall), 32'd0);
    chk("rst_mid_ack", 32'(dbg_ack), 32'd0);
    chk("rst_mid_rdata", dbg_rdata, 32'd0);
    repeat (3) step();
    chk("rst_mid_idle", 32'(pipe_stall), 32'd0);

    start_req(1'b0, 5'd9, 32'h0, e0);
    ack_q.push_back('{e0 + 3, 32'hCAFE0009, 1'b0});
    finish_req();

`ifdef RF_DBG_ARB_TIMEOUT_EN
    // Drain never completes: error ack after the counter expires, no write.
    pipe_idle = 1'b0;
    start_req(1'b1, 5'd7, 32'hFFFFFFFF, e0);
    ack_q.push_back('{e0 + 8, 32'hCAFE0009, 1'b1});
    finish_req();
    pipe_idle = 1'b1;

    start_req(1'b0, 5'd7, 32'h0, e0);
    ack_q.push_back('{e0 + 3, 32'h77, 1'b0});
    finish_req();
`endif

    repeat (3) step();
    chk("ack_q_drained", ack_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
